// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage feeding the ALU from a synchronous-read instruction memory
// One-cycle fetch latency: branches squash the branch cycle, stalls replay the held word.
module fetch_stage #(
  parameter int ADDR_W   = 12,
  parameter int BOOT_RUN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [32:0]       fork_cxt,
  input  logic              branch_en,
  input  logic [15:0]       branch_val,
  input  logic              stall,
  input  logic [15:0]       current_ins,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic [15:0]       ins_out,
  output logic              running,
  output logic [ADDR_W-1:0] fetch_pc
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  localparam state_t            RST_STATE = (BOOT_RUN != 0) ? S_RUN : S_IDLE;
  localparam logic [ADDR_W-1:0] ONE       = 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] fpc, fpc_nxt;
  logic              fvalid, fvalid_nxt;

  logic              fork_go;
  logic [ADDR_W-1:0] fork_pc;
  logic [ADDR_W-1:0] br_tgt;
  logic              unused_bits;

  assign fork_go     = fork_cxt[32];
  assign fork_pc     = fork_cxt[ADDR_W-1:0];
  assign br_tgt      = branch_val[ADDR_W-1:0];
  // Data pointer and high target bits are intentionally ignored here.
  assign unused_bits = ^{fork_cxt[31:0], branch_val};

  assign running  = (state == S_RUN);
  assign fetch_pc = fpc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RST_STATE;
      pc     <= '0;
      fpc    <= '0;
      fvalid <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      fpc    <= fpc_nxt;
      fvalid <= fvalid_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    fpc_nxt    = fpc;
    fvalid_nxt = fvalid;
    ins_out    = 16'h0000;
    imem_addr  = pc;

    if (rst) begin
      imem_addr = '0;
    end else if (fork_go) begin
      state_nxt  = S_RUN;
      pc_nxt     = fork_pc;
      fvalid_nxt = 1'b0;
    end else if (state == S_RUN) begin
      if (branch_en) begin
        imem_addr  = br_tgt;
        fpc_nxt    = br_tgt;
        pc_nxt     = br_tgt + ONE;
        fvalid_nxt = 1'b1;
      end else if (stall) begin
        // Re-read the held address so imem_data still carries it when stall drops.
        ins_out   = current_ins;
        imem_addr = fpc;
      end else if (fvalid && imem_data[15:12] == 4'hF) begin
        ins_out    = imem_data;
        state_nxt  = S_HALTED;
        fvalid_nxt = 1'b0;
      end else begin
        ins_out    = fvalid ? imem_data : 16'h0000;
        fpc_nxt    = pc;
        pc_nxt     = pc + ONE;
        fvalid_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [32:0] fork_cxt;
  logic        branch_en;
  logic [15:0] branch_val;
  logic        stall;
  logic [15:0] current_ins;

  logic [11:0] addr0, addr1, fpc0, fpc1;
  logic [15:0] data0, data1, ins0, ins1;
  logic        run0, run1;

  logic [15:0] mem [0:4095];

  int n_chk;
  int n_err;

  fetch_stage #(.ADDR_W(12), .BOOT_RUN(1)) u_boot (
    .clk(clk), .rst(rst), .fork_cxt(fork_cxt), .branch_en(branch_en),
    .branch_val(branch_val), .stall(stall), .current_ins(current_ins),
    .imem_addr(addr0), .imem_data(data0), .ins_out(ins0),
    .running(run0), .fetch_pc(fpc0)
  );

  fetch_stage #(.ADDR_W(12), .BOOT_RUN(0)) u_idle (
    .clk(clk), .rst(rst), .fork_cxt(fork_cxt), .branch_en(branch_en),
    .branch_val(branch_val), .stall(stall), .current_ins(current_ins),
    .imem_addr(addr1), .imem_data(data1), .ins_out(ins1),
    .running(run1), .fetch_pc(fpc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory, one port per DUT
  always @(posedge clk) begin
    data0 <= mem[addr0];
    data1 <= mem[addr1];
  end

  typedef struct {
    logic        fk;
    logic [15:0] fk_pc;
    logic        br;
    logic [15:0] bv;
    logic        st;
    logic [15:0] cur;
    logic [15:0] e_ins;
    logic [11:0] e_addr;
    logic        c_addr;
    logic        e_run;
    logic [11:0] e_fpc;
    logic        c_fpc;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic fk, input logic [15:0] fk_pc, input logic br, input logic [15:0] bv,
                     input logic st, input logic [15:0] cur, input logic [15:0] e_ins,
                     input logic [11:0] e_addr, input logic c_addr, input logic e_run,
                     input logic [11:0] e_fpc, input logic c_fpc);
    vec_t v;
    v.fk = fk; v.fk_pc = fk_pc; v.br = br; v.bv = bv; v.st = st; v.cur = cur;
    v.e_ins = e_ins; v.e_addr = e_addr; v.c_addr = c_addr; v.e_run = e_run;
    v.e_fpc = e_fpc; v.c_fpc = c_fpc;
    tv.push_back(v);
  endtask

  task automatic drive(input logic fk, input logic [15:0] fk_pc, input logic br,
                       input logic [15:0] bv, input logic st, input logic [15:0] cur);
    fork_cxt    = {fk, 16'h0080, fk_pc};
    branch_en   = br;
    branch_val  = bv;
    stall       = st;
    current_ins = cur;
  endtask

  // Reference model state: whether running, next issue address, and the fetch in flight
  logic        m_run;
  logic [11:0] m_pc;
  logic [11:0] m_pa;
  logic        m_pv;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 4096; i++) mem[i] = 16'h1000 | 16'(i);
    mem[1] = 16'h3000;
    mem[2] = 16'h2000;
    mem[7] = 16'hF000;

    //   fk  fk_pc    br  bv       st  cur      ins      addr    ca  run fpc     cf
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 12'h000, 1, 1, 12'h000, 1);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h1000, 12'h001, 1, 1, 12'h000, 1);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h3000, 12'h002, 1, 1, 12'h001, 1);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h2000, 12'h003, 1, 1, 12'h002, 1);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h1003, 12'h004, 1, 1, 12'h003, 1);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h1004, 12'h005, 1, 1, 12'h004, 1);
    add(0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0000, 12'h040, 1, 1, 12'h005, 1);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h1040, 12'h041, 1, 1, 12'h040, 1);
    add(0, 16'h0000, 0, 16'h0000, 1, 16'h8203, 16'h8203, 12'h041, 1, 1, 12'h041, 1);
    add(0, 16'h0000, 0, 16'h0000, 1, 16'h8203, 16'h8203, 12'h041, 1, 1, 12'h041, 1);
    add(0, 16'h0000, 0, 16'h0000, 1, 16'h8203, 16'h8203, 12'h041, 1, 1, 12'h041, 1);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h1041, 12'h042, 1, 1, 12'h041, 1);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h1042, 12'h043, 1, 1, 12'h042, 1);
    add(0, 16'h0000, 1, 16'h1005, 1, 16'h8203, 16'h0000, 12'h005, 1, 1, 12'h043, 1);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h1005, 12'h006, 1, 1, 12'h005, 1);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h1006, 12'h007, 1, 1, 12'h006, 1);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'hF000, 12'h008, 1, 1, 12'h007, 1);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 12'h000, 0, 0, 12'h000, 0);
    add(1, 16'h0010, 1, 16'h0040, 0, 16'h0000, 16'h0000, 12'h000, 0, 0, 12'h000, 0);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 12'h010, 1, 1, 12'h000, 0);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h1010, 12'h011, 1, 1, 12'h010, 1);
    add(0, 16'h0000, 1, 16'h0FFF, 0, 16'h0000, 16'h0000, 12'hFFF, 1, 1, 12'h011, 1);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h1FFF, 12'h000, 1, 1, 12'hFFF, 1);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h1000, 12'h001, 1, 1, 12'h000, 1);
    add(0, 16'h0000, 0, 16'h0000, 1, 16'h1234, 16'h1234, 12'h001, 1, 1, 12'h001, 1);

    // Reset values, with a fork request that reset must override
    repeat (2) @(posedge clk);
    drive(1'b1, 16'h0123, 1'b1, 16'h0055, 1'b0, 16'h0);
    @(negedge clk);
    check("rst_ins_boot", 32'(ins0), 32'h0);
    check("rst_addr_boot", 32'(addr0), 32'h0);
    check("rst_run_boot", 32'(run0), 32'h1);
    check("rst_run_idle", 32'(run1), 32'h0);
    check("rst_addr_idle", 32'(addr1), 32'h0);
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].fk, tv[i].fk_pc, tv[i].br, tv[i].bv, tv[i].st, tv[i].cur);
      @(negedge clk);
      check($sformatf("v%0d_ins", i), 32'(ins0), 32'(tv[i].e_ins));
      check($sformatf("v%0d_run", i), 32'(run0), 32'(tv[i].e_run));
      if (tv[i].c_addr) check($sformatf("v%0d_addr", i), 32'(addr0), 32'(tv[i].e_addr));
      if (tv[i].c_fpc) check($sformatf("v%0d_fpc", i), 32'(fpc0), 32'(tv[i].e_fpc));
      // Idle-boot core only comes alive at the fork in vector 18
      if (i < 19) begin
        check($sformatf("v%0d_idle_ins", i), 32'(ins1), 32'h0);
        check($sformatf("v%0d_idle_run", i), 32'(run1), 32'h0);
      end else begin
        check($sformatf("v%0d_idle_ins", i), 32'(ins1), 32'(tv[i].e_ins));
        check($sformatf("v%0d_idle_run", i), 32'(run1), 32'(tv[i].e_run));
        if (tv[i].c_addr) check($sformatf("v%0d_idle_addr", i), 32'(addr1), 32'(tv[i].e_addr));
      end
      @(posedge clk);
      #1;
    end

    // Reset asserted mid-stall, between clock edges
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h1234);
    #3 rst = 1'b1;
    #1;
    check("midrst_ins", 32'(ins0), 32'h0);
    check("midrst_addr", 32'(addr0), 32'h0);
    check("midrst_fpc", 32'(fpc0), 32'h0);
    check("midrst_run", 32'(run0), 32'h1);
    check("midrst_idle_run", 32'(run1), 32'h0);
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("boot_c0_ins", 32'(ins0), 32'h0);
    check("boot_c0_addr", 32'(addr0), 32'h0);
    @(negedge clk);
    check("boot_c1_ins", 32'(ins0), 32'h1000);
    @(posedge clk);

    // Randomized run against the reference model
    #1 rst = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:12] == 4'hF && $urandom_range(0, 3) != 0) w[15:12] = 4'h7;
      mem[i] = w;
    end
    m_run = 1'b1; m_pc = 12'h0; m_pa = 12'h0; m_pv = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    for (int n = 0; n < 600; n++) begin
      logic        fk, br, st, c_addr;
      logic [15:0] fk_pc, bv, cur, e_ins;
      logic [11:0] e_addr;
      fk    = ($urandom_range(0, 15) == 0);
      br    = ($urandom_range(0, 7) == 0);
      st    = ($urandom_range(0, 4) == 0);
      fk_pc = 16'($urandom);
      bv    = 16'($urandom);
      cur   = 16'($urandom);
      drive(fk, fk_pc, br, bv, st, cur);

      c_addr = 1'b1;
      e_addr = m_pc;
      e_ins  = 16'h0;
      if (fk) c_addr = 1'b0;
      else if (!m_run) e_ins = 16'h0;
      else if (br) e_addr = bv[11:0];
      else if (st) begin e_ins = cur; e_addr = m_pa; end
      else e_ins = m_pv ? mem[m_pa] : 16'h0;

      @(negedge clk);
      check($sformatf("r%0d_ins", n), 32'(ins0), 32'(e_ins));
      check($sformatf("r%0d_run", n), 32'(run0), 32'(m_run));
      if (c_addr) check($sformatf("r%0d_addr", n), 32'(addr0), 32'(e_addr));
      if (m_run && m_pv) check($sformatf("r%0d_fpc", n), 32'(fpc0), 32'(m_pa));

      if (fk) begin
        m_run = 1'b1; m_pc = fk_pc[11:0]; m_pv = 1'b0;
      end else if (m_run) begin
        if (br) begin
          m_pa = bv[11:0]; m_pv = 1'b1; m_pc = bv[11:0] + 12'd1;
        end else if (st) begin
          m_pc = m_pc;
        end else if (m_pv && mem[m_pa][15:12] == 4'hF) begin
          m_run = 1'b0; m_pv = 1'b0;
        end else begin
          m_pa = m_pc; m_pv = 1'b1; m_pc = m_pc + 12'd1;
        end
      end
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
